// File: rtl/uart_pkt_rx_if.sv
// ---------------------------------------------------------------------------
// uart_pkt_rx_if
// Bundles the two sides of the packet receiver:
//   FIFO side   : rx_empty, r_data (first-word-fall-through head), rd_uart (pop)
//   Stream side : m_data, m_valid, m_ready, m_last (payload bytes to consumer)
//   Status      : frame_ok / frame_err one-cycle pulses, err_code held cause
// modport master : the receiver's view (drives rd_uart, stream and status)
// modport slave  : the environment's view (drives FIFO flags/data and m_ready)
// ---------------------------------------------------------------------------
interface uart_pkt_rx_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    input  rx_empty, r_data, m_ready,
    output rd_uart, m_data, m_valid, m_last, frame_ok, frame_err, err_code
  );

  modport slave (
    output rx_empty, r_data, m_ready,
    input  rd_uart, m_data, m_valid, m_last, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_pkt_rx.sv
// ---------------------------------------------------------------------------
// uart_pkt_rx
// Pulls bytes from a UART RX FIFO and parses frames of the form
//   SOF_BYTE, LEN, LEN payload bytes, CHK   (CHK = XOR of LEN and payload)
// Payload bytes are presented on a valid/ready stream with m_last on the
// final byte. Each frame ends with a one-cycle frame_ok or frame_err pulse;
// err_code keeps the cause of the latest error (01 length, 10 checksum,
// 11 inter-byte timeout).
// Ports:
//   clk  - single rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - uart_pkt_rx_if.master (FIFO side, stream side, status)
// ---------------------------------------------------------------------------
module uart_pkt_rx #(
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 60000
) (
  input  logic          clk,
  input  logic          rst,
  uart_pkt_rx_if.master bus
);

  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [7:0]    len_cnt_r;
  logic [7:0]    len_cnt_s;
  logic [7:0]    xor_r;
  logic [7:0]    xor_s;
  logic [TW-1:0] tmo_r;
  logic          ok_s;
  logic          err_s;
  logic [1:0]    code_s;
  logic          frame_ok_r;
  logic          frame_err_r;
  logic [1:0]    err_code_r;
  logic [7:0]    m_data_r;
  logic          m_valid_r;
  logic          m_last_r;
  logic          rd_s;
  logic          pop_s;
  logic          load_s;
  logic          accept_s;
  logic          stall_s;
  logic          timeout_s;

  // FIFO pop strobe: payload bytes may only be popped when the output slot frees up
  always_comb begin
    rd_s = 1'b0;
    if (!rst) begin
      rd_s = 1'b0;
    end else if (bus.rx_empty) begin
      rd_s = 1'b0;
    end else if (state_r == PAYLOAD) begin
      rd_s = !m_valid_r || bus.m_ready;
    end else begin
      rd_s = 1'b1;
    end
  end

  assign pop_s    = rd_s;
  assign load_s   = pop_s && (state_r == PAYLOAD);
  assign accept_s = m_valid_r && bus.m_ready;
  // A byte is waiting but the consumer is holding us off: not an idle line.
  assign stall_s  = (state_r == PAYLOAD) && !bus.rx_empty && m_valid_r && !bus.m_ready;
  // Fires on the idle cycle that would bring the counter to TIMEOUT_CYC.
  assign timeout_s = (state_r != IDLE) && !pop_s && !stall_s && (tmo_r == TMO_LAST);

  // Frame parser next-state, length/checksum updates and status pulses
  always_comb begin
    state_s   = state_r;
    len_cnt_s = len_cnt_r;
    xor_s     = xor_r;
    ok_s      = 1'b0;
    err_s     = 1'b0;
    code_s    = err_code_r;
    case (state_r)
      IDLE: begin
        if (pop_s && (bus.r_data == SOF_BYTE)) begin
          state_s = LEN;
        end else begin
          state_s = IDLE;
        end
      end
      LEN: begin
        if (pop_s) begin
          if ((bus.r_data == 8'd0) || (bus.r_data > MAX_LEN_B)) begin
            err_s   = 1'b1;
            code_s  = 2'b01;
            state_s = IDLE;
          end else begin
            len_cnt_s = bus.r_data;
            xor_s     = bus.r_data;
            state_s   = PAYLOAD;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          code_s  = 2'b11;
          state_s = IDLE;
        end else begin
          state_s = LEN;
        end
      end
      PAYLOAD: begin
        if (pop_s) begin
          xor_s     = xor_r ^ bus.r_data;
          len_cnt_s = len_cnt_r - 8'd1;
          if (len_cnt_r == 8'd1) begin
            state_s = CHK;
          end else begin
            state_s = PAYLOAD;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          code_s  = 2'b11;
          state_s = IDLE;
        end else begin
          state_s = PAYLOAD;
        end
      end
      CHK: begin
        if (pop_s) begin
          if (bus.r_data == xor_r) begin
            ok_s = 1'b1;
          end else begin
            err_s  = 1'b1;
            code_s = 2'b10;
          end
          state_s = IDLE;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          code_s  = 2'b11;
          state_s = IDLE;
        end else begin
          state_s = CHK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Parser state, length counter, running XOR and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      len_cnt_r   <= 8'd0;
      xor_r       <= 8'd0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'b00;
    end else begin
      state_r     <= state_s;
      len_cnt_r   <= len_cnt_s;
      xor_r       <= xor_s;
      frame_ok_r  <= ok_s;
      frame_err_r <= err_s;
      err_code_r  <= code_s;
    end
  end

  // Inter-byte timeout counter: cleared by any pop or while idle, frozen on consumer stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_r <= '0;
    end else if (pop_s || (state_r == IDLE) || timeout_s) begin
      tmo_r <= '0;
    end else if (stall_s) begin
      tmo_r <= tmo_r;
    end else begin
      tmo_r <= tmo_r + TW'(1);
    end
  end

  // Payload output slot: a same-cycle load and handshake replaces the byte with no bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_r  <= 8'd0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (load_s) begin
      m_data_r  <= bus.r_data;
      m_valid_r <= 1'b1;
      m_last_r  <= (len_cnt_r == 8'd1);
    end else if (accept_s) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

  assign bus.rd_uart   = rd_s;
  assign bus.m_data    = m_data_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_last    = m_last_r;
  assign bus.frame_ok  = frame_ok_r;
  assign bus.frame_err = frame_err_r;
  assign bus.err_code  = err_code_r;

endmodule
